// File: rtl/hexsched_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hexsched_pkg                                                     |
// | Shared constants for the hex display scheduler slice.            |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package hexsched_pkg;

   localparam int         c_max_digits = 8;
   localparam int         c_ptr_w      = 3;
   localparam logic [6:0] c_blank_seg  = 7'h7F;

   // Sweep sequencer states
   localparam logic [1:0] c_st_idle    = 2'd0;
   localparam logic [1:0] c_st_drive   = 2'd1;
   localparam logic [1:0] c_st_capture = 2'd2;
   localparam logic [1:0] c_st_done    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/hexsched_blank_mask.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hexsched_blank_mask                                              |
// | Effective per-digit blank mask; leading-zero suppression when    |
// | HEXSCHED_LZS_EN is defined.                                      |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module hexsched_blank_mask
   import hexsched_pkg::*;
#(
   parameter int NUM_DIGITS = 6
) (
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   load_blank,
   output logic [NUM_DIGITS-1:0]   eff_blank
);

   logic [NUM_DIGITS-1:0] w_lzs;

`ifdef HEXSCHED_LZS_EN
   logic w_seen_nonzero;
   logic w_unused_low;

   // Digit 0 never takes part, so a zero value still shows one "0"
   always_comb begin
      w_lzs          = '0;
      w_seen_nonzero = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         if (value[4*i +: 4] != 4'h0) w_seen_nonzero = 1'b1;
         if (!w_seen_nonzero)         w_lzs[i]       = 1'b1;
      end
   end

   assign w_unused_low = ^value[3:0];
`else
   logic w_unused_value;

   assign w_lzs          = '0;
   assign w_unused_value = ^value;
`endif

   assign eff_blank = load_blank | w_lzs;

endmodule
`default_nettype wire

// File: rtl/hex_display_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hex_display_scheduler                                            |
// | Time-shares one hex-to-7-segment decoder across NUM_DIGITS       |
// | digits. Optional feature macro: HEXSCHED_LZS_EN.                 |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module hex_display_scheduler
   import hexsched_pkg::*;
#(
   parameter int         NUM_DIGITS = 6,
   parameter logic [6:0] BLANK_SEG  = c_blank_seg
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [4*NUM_DIGITS-1:0] load_value,
   input  logic [NUM_DIGITS-1:0]   load_blank,
   output logic [3:0]              dec_x,
   input  logic [6:0]              dec_y,
   output logic [7*NUM_DIGITS-1:0] seg_out,
   output logic                    busy,
   output logic                    done
);

   logic [1:0]              r_state;
   logic [c_ptr_w-1:0]      r_ptr;
   logic [4*NUM_DIGITS-1:0] r_value;
   logic [NUM_DIGITS-1:0]   r_blank;
   logic                    r_out_of_reset;

   logic [NUM_DIGITS-1:0]   w_eff_blank;
   logic                    w_accept;
   logic                    w_last;
   logic                    w_sweeping;
   logic [3:0]              w_nibble;

   hexsched_blank_mask #(
      .NUM_DIGITS (NUM_DIGITS)
   ) u_blank_mask (
      .value      (load_value),
      .load_blank (load_blank),
      .eff_blank  (w_eff_blank)
   );

   // Ready is held off for the first cycle after reset release
   assign load_ready = r_out_of_reset && (r_state == c_st_idle);
   assign w_accept   = load_valid && load_ready;
   assign w_last     = (r_ptr == c_ptr_w'(NUM_DIGITS - 1));
   assign w_sweeping = (r_state == c_st_drive) || (r_state == c_st_capture);

   always_comb begin
      w_nibble = 4'h0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_ptr == c_ptr_w'(i)) w_nibble = r_value[4*i +: 4];
      end
   end

   assign dec_x = w_sweeping ? w_nibble : 4'h0;
   assign busy  = w_sweeping;
   assign done  = (r_state == c_st_done);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= c_st_idle;
         r_ptr          <= '0;
         r_value        <= '0;
         r_blank        <= '0;
         r_out_of_reset <= 1'b0;
      end else begin
         r_out_of_reset <= 1'b1;
         case (r_state)
            c_st_idle: begin
               if (w_accept) begin
                  r_value <= load_value;
                  r_blank <= w_eff_blank;
                  r_ptr   <= '0;
                  r_state <= c_st_drive;
               end
            end
            c_st_drive: begin
               r_state <= c_st_capture;
            end
            c_st_capture: begin
               if (w_last) begin
                  r_state <= c_st_done;
               end else begin
                  r_ptr   <= r_ptr + 1'b1;
                  r_state <= c_st_drive;
               end
            end
            c_st_done: begin
               r_state <= c_st_idle;
            end
            default: begin
               r_state <= c_st_idle;
            end
         endcase
      end
   end

   // Each digit only updates on its own capture slot, so untouched digits persist
   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      logic [6:0] r_seg;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_seg <= BLANK_SEG;
         end else if ((r_state == c_st_capture) && (r_ptr == c_ptr_w'(g))) begin
            r_seg <= r_blank[g] ? BLANK_SEG : dec_y;
         end
      end

      assign seg_out[7*g +: 7] = r_seg;
   end

endmodule
`default_nettype wire
